control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters: none; opcode values and output encodings SHALL be fixed constants.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instruction opcode field [31:26].
REQ-005 MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  writeback-from-memory, register-file write, data-memory read, data-memory write.
REQ-006 extended  output  1  sign-extend a sub-word load (1) or zero-extend (0).
REQ-007 luiControl  output  1  write the immediate shifted left 16.
REQ-008 load  output  2  access size: 00 word, 01 byte, 10 halfword, 11 unused.
REQ-009 AluOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-010 AluSrc, regDest  output  1 each  ALU operand B from immediate; destination register is rd (else rt).
REQ-011 branch, j, jal, jr  output  1 each  beq, jump, jump-and-link, jump-register.

Function
REQ-012 Decode SHALL be registered: the opcode is sampled on each rising clk edge and all outputs update together, giving 1-cycle latency and no combinational path from opcode to outputs.
REQ-013 Loads: 100000 lb, 100001 lh, 100100 lbu, 100101 lhu, 100011 lw SHALL drive RegWrite=1, MemtoReg=1, MemRead=1, AluSrc=1, AluOp=00, and all other flags 0.
REQ-014 Load sizes and extension: lb load=01 extended=1; lh load=10 extended=1; lbu load=01 extended=0; lhu load=10 extended=0; lw load=00 extended=0.
REQ-015 Stores: 101000 sb (load=01), 101001 sh (load=10), 101011 sw (load=00) SHALL drive MemWrite=1, AluSrc=1, AluOp=00, and all other flags 0.
REQ-016 001111 lui SHALL drive RegWrite=1, luiControl=1, AluSrc=1, AluOp=00, all else 0.
REQ-017 000000 R-type SHALL drive RegWrite=1, regDest=1, AluOp=10, all else 0.
REQ-018 000010 j SHALL drive j=1; 000011 jal SHALL drive jal=1 and RegWrite=1 (link register 31); 001000 jr SHALL drive jr=1; all other outputs 0 in each case.
REQ-019 000100 beq SHALL drive branch=1 and AluOp=01, all else 0.
REQ-020 Any other opcode SHALL decode as NOP: all outputs 0.
REQ-021 At most one of branch, j, jal, jr SHALL be 1, and MemRead and MemWrite SHALL never both be 1.

Reset
REQ-022 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-023 After rst_n deasserts, the first rising edge SHALL load the decode of the current opcode.
REQ-024 Reset asserted mid-stream SHALL discard the pending decode.

Configuration
REQ-025 When CONTROL_UNIT_ILLEGAL_OP_EN is defined, an extra 1-bit output illegal_op SHALL be registered with the other outputs: 1 for any opcode not listed in REQ-013..REQ-019, 0 otherwise, and 0 during reset.
REQ-026 When CONTROL_UNIT_ILLEGAL_OP_EN is not defined, the port SHALL be absent and behaviour is otherwise identical.

Structure
REQ-027 Opcode constants, the load-size and AluOp encodings, and a packed control-word typedef SHALL reside in a shared package, ctrl_pkg.
REQ-028 A pure-combinational sub-module, control_decode (opcode -> control word), SHALL feed a single output register stage in control_unit.

Verification
REQ-029 Hold rst_n=0 with opcode=000000 and toggle clk -> all outputs 0; deassert rst_n, one edge -> RegWrite=1, regDest=1, AluOp=10.
REQ-030 Apply the sequence 100000, 100100, 100001, 100101, 001111, 100011 -> each opcode's values appear one cycle later: extended 1,0,1,0,0,0 and load 01,01,10,10,00,00; luiControl=1 only for 001111.
REQ-031 Apply 101000, 101001, 101011 -> MemWrite=1, RegWrite=0, load 01, 10, 00.
REQ-032 Apply 000010, 000011, 001000, 000100 -> exactly j, then jal (with RegWrite=1), then jr, then branch (with AluOp=01) set.
REQ-033 Apply 111111 -> all outputs 0; with CONTROL_UNIT_ILLEGAL_OP_EN defined, illegal_op=1.
REQ-034 Assert rst_n=0 between clock edges while 100011 is decoded -> outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg -- shared constants and types for the control unit.
//   * 6-bit opcode constants for every decoded instruction
//   * load-size and ALU-operation encodings
//   * ctrl_word_t : packed control word produced by control_decode and
//                   registered by control_unit
// Optional feature macro: CONTROL_UNIT_ILLEGAL_OP_EN adds the illegal_op bit
// to the control word.
// ----------------------------------------------------------------------------
package ctrl_pkg;

  // Opcode field [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JR    = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Memory access size (11 is reserved)
  typedef enum logic [1:0] {
    LOAD_WORD = 2'b00,
    LOAD_BYTE = 2'b01,
    LOAD_HALF = 2'b10
  } load_size_e;

  // ALU operation class
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    logic       illegal_op;
`endif
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       extended;
    logic       lui_control;
    load_size_e load;
    alu_op_e    alu_op;
    logic       alu_src;
    logic       reg_dest;
    logic       branch;
    logic       j;
    logic       jal;
    logic       jr;
  } ctrl_word_t;

  // All-zero word: the NOP decode and the reset value
  localparam ctrl_word_t CTRL_NOP = '0;

endpackage : ctrl_pkg

// File: rtl/control_unit_if.sv
// ----------------------------------------------------------------------------
// control_unit_if -- opcode in, decoded control signals out.
//   master modport : instruction source (drives opcode, observes controls)
//   slave  modport : control_unit (samples opcode, drives controls)
// Optional feature macro: CONTROL_UNIT_ILLEGAL_OP_EN adds illegal_op.
// ----------------------------------------------------------------------------
interface control_unit_if;

  logic [5:0] opcode;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       extended;
  logic       luiControl;
  logic [1:0] load;
  logic [1:0] AluOp;
  logic       AluSrc;
  logic       regDest;
  logic       branch;
  logic       j;
  logic       jal;
  logic       jr;
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
  logic       illegal_op;
`endif

  modport master (
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    input  illegal_op,
`endif
    output opcode,
    input  MemtoReg, RegWrite, MemRead, MemWrite, extended, luiControl,
    input  load, AluOp, AluSrc, regDest, branch, j, jal, jr
  );

  modport slave (
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    output illegal_op,
`endif
    input  opcode,
    output MemtoReg, RegWrite, MemRead, MemWrite, extended, luiControl,
    output load, AluOp, AluSrc, regDest, branch, j, jal, jr
  );

endinterface : control_unit_if

// File: rtl/control_decode.sv
// ----------------------------------------------------------------------------
// control_decode -- purely combinational opcode -> control word decoder.
//   opcode_i [5:0]  instruction opcode field
//   ctrl_o          decoded control word (ctrl_pkg::ctrl_word_t)
// Unlisted opcodes decode to the all-zero NOP word. With
// CONTROL_UNIT_ILLEGAL_OP_EN defined, they also raise illegal_op.
// ----------------------------------------------------------------------------
module control_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_word_t ctrl_o
);

  // Opcode decode; every path starts from the NOP word so each case only
  // lists the flags it raises.
  always_comb begin
    ctrl_o = CTRL_NOP;
    case (opcode_i)
      OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        // Sub-word sizes; only lb/lh sign-extend
        if ((opcode_i == OP_LB) || (opcode_i == OP_LBU)) begin
          ctrl_o.load = LOAD_BYTE;
        end else if ((opcode_i == OP_LH) || (opcode_i == OP_LHU)) begin
          ctrl_o.load = LOAD_HALF;
        end else begin
          ctrl_o.load = LOAD_WORD;
        end
        ctrl_o.extended = (opcode_i == OP_LB) || (opcode_i == OP_LH);
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        if (opcode_i == OP_SB) begin
          ctrl_o.load = LOAD_BYTE;
        end else if (opcode_i == OP_SH) begin
          ctrl_o.load = LOAD_HALF;
        end else begin
          ctrl_o.load = LOAD_WORD;
        end
      end
      OP_LUI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.lui_control = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_op      = ALU_ADD;
      end
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dest  = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      OP_J: begin
        ctrl_o.j = 1'b1;
      end
      OP_JAL: begin
        // Link write to r31 is handled by the datapath
        ctrl_o.jal       = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_JR: begin
        ctrl_o.jr = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      default: begin
        ctrl_o = CTRL_NOP;
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
        ctrl_o.illegal_op = 1'b1;
`endif
      end
    endcase
  end

endmodule : control_decode

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit -- registered instruction decoder.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all outputs immediately
//   bus    control_unit_if.slave: opcode in; MemtoReg, RegWrite, MemRead,
//          MemWrite, extended, luiControl, load, AluOp, AluSrc, regDest,
//          branch, j, jal, jr out (plus illegal_op when
//          CONTROL_UNIT_ILLEGAL_OP_EN is defined)
// The opcode is decoded combinationally and captured in one register
// stage, so every output changes together one cycle after the opcode.
// ----------------------------------------------------------------------------
module control_unit
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  bus
);

  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_q;

  control_decode u_decode (
    .opcode_i (bus.opcode),
    .ctrl_o   (ctrl_d)
  );

  // Single output register stage; reset drops any pending decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.MemtoReg   = ctrl_q.mem_to_reg;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.MemRead    = ctrl_q.mem_read;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.extended   = ctrl_q.extended;
  assign bus.luiControl = ctrl_q.lui_control;
  assign bus.load       = ctrl_q.load;
  assign bus.AluOp      = ctrl_q.alu_op;
  assign bus.AluSrc     = ctrl_q.alu_src;
  assign bus.regDest    = ctrl_q.reg_dest;
  assign bus.branch     = ctrl_q.branch;
  assign bus.j          = ctrl_q.j;
  assign bus.jal        = ctrl_q.jal;
  assign bus.jr         = ctrl_q.jr;
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
  assign bus.illegal_op = ctrl_q.illegal_op;
`endif

endmodule : control_unit

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit -- directed self-checking bench for control_unit.
// Output word layout used for comparisons (16 bits):
//   [15] MemtoReg [14] RegWrite [13] MemRead [12] MemWrite
//   [11] extended [10] luiControl [9:8] load
//   [7:6] AluOp [5] AluSrc [4] regDest
//   [3] branch [2] j [1] jal [0] jr
// Optional feature macro: CONTROL_UNIT_ILLEGAL_OP_EN (illegal_op checks).
// ----------------------------------------------------------------------------
module tb_control_unit;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  control_unit_if cu_if ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cu_if.slave)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed expected words
  localparam logic [15:0] W_NOP = 16'b0000_0000_0000_0000;
  localparam logic [15:0] W_R   = 16'b0100_0000_1001_0000;
  localparam logic [15:0] W_LB  = 16'b1110_1001_0010_0000;
  localparam logic [15:0] W_LBU = 16'b1110_0001_0010_0000;
  localparam logic [15:0] W_LH  = 16'b1110_1010_0010_0000;
  localparam logic [15:0] W_LHU = 16'b1110_0010_0010_0000;
  localparam logic [15:0] W_LW  = 16'b1110_0000_0010_0000;
  localparam logic [15:0] W_LUI = 16'b0100_0100_0010_0000;
  localparam logic [15:0] W_SB  = 16'b0001_0001_0010_0000;
  localparam logic [15:0] W_SH  = 16'b0001_0010_0010_0000;
  localparam logic [15:0] W_SW  = 16'b0001_0000_0010_0000;
  localparam logic [15:0] W_J   = 16'b0000_0000_0000_0100;
  localparam logic [15:0] W_JAL = 16'b0100_0000_0000_0010;
  localparam logic [15:0] W_JR  = 16'b0000_0000_0000_0001;
  localparam logic [15:0] W_BEQ = 16'b0000_0000_0100_1000;

  localparam int N_VEC = 19;
  logic [5:0]  vec_op  [N_VEC] = '{
    6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b001111, 6'b100011,
    6'b101000, 6'b101001, 6'b101011,
    6'b000010, 6'b000011, 6'b001000, 6'b000100,
    6'b111111, 6'b000000, 6'b000001, 6'b100010, 6'b101010, 6'b000100
  };
  logic [15:0] vec_exp [N_VEC] = '{
    W_LB, W_LBU, W_LH, W_LHU, W_LUI, W_LW,
    W_SB, W_SH, W_SW,
    W_J, W_JAL, W_JR, W_BEQ,
    W_NOP, W_R, W_NOP, W_NOP, W_NOP, W_BEQ
  };
  logic        vec_ill [N_VEC] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0
  };

  logic [15:0] prev_exp;
  logic        prev_ill;

  function automatic logic [15:0] obs_word();
    return {cu_if.MemtoReg, cu_if.RegWrite, cu_if.MemRead, cu_if.MemWrite,
            cu_if.extended, cu_if.luiControl, cu_if.load,
            cu_if.AluOp, cu_if.AluSrc, cu_if.regDest,
            cu_if.branch, cu_if.j, cu_if.jal, cu_if.jr};
  endfunction

  // Single comparison point: counts every check, reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] exp,
                               input logic ill);
    logic [15:0] w;
    w = obs_word();
    check_eq(tag, 32'(w), 32'(exp));
    // Structural invariants: one control-transfer flag, no read+write
    check_eq({tag, "_flow1hot"},
             32'((32'(w[3]) + 32'(w[2]) + 32'(w[1]) + 32'(w[0])) <= 32'd1),
             32'd1);
    check_eq({tag, "_rdwr"}, 32'(w[13] & w[12]), 32'd0);
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    check_eq({tag, "_illegal"}, 32'(cu_if.illegal_op), 32'(ill));
`else
    if (ill) begin
      // illegal_op port absent in this build
    end else begin
    end
`endif
  endtask

  // Drive an opcode after a falling edge, confirm outputs have not moved
  // yet, then confirm the new decode after the next rising edge.
  task automatic apply(input string tag, input logic [5:0] op,
                       input logic [15:0] exp, input logic ill);
    @(negedge clk);
    cu_if.opcode = op;
    #1;
    check_outputs({tag, "_hold"}, prev_exp, prev_ill);
    @(posedge clk);
    #1;
    check_outputs(tag, exp, ill);
    prev_exp = exp;
    prev_ill = ill;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    cu_if.opcode = 6'b000000;

    // Outputs clear in reset, before and after clock edges
    #1;
    check_outputs("rst_immediate", W_NOP, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("rst_held", W_NOP, 1'b0);

    // Release between edges; first rising edge loads R-type
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst_release_pre", W_NOP, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_release_rtype", W_R, 1'b0);
    prev_exp = W_R;
    prev_ill = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      apply($sformatf("vec%0d_op%b", i, vec_op[i]), vec_op[i], vec_exp[i],
            vec_ill[i]);
    end

    // Mid-stream reset while lw is decoded: clears without a clock edge
    apply("lw_before_rst", 6'b100011, W_LW, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("rst_async_clear", W_NOP, 1'b0);

    // Pending opcode during reset is discarded
    @(negedge clk);
    cu_if.opcode = 6'b000100;
    @(posedge clk);
    #1;
    check_outputs("rst_discard", W_NOP, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst2_release_pre", W_NOP, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst2_first_edge", W_BEQ, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_control_unit
